// File: rtl/esi_manifest_mmio_reader.sv
// Read-only MMIO window onto the compressed ESI manifest: magic, header, then
// the manifest bytes packed little-endian into 64-bit words. Two-stage pipeline.
module esi_manifest_mmio_reader #(
  parameter int unsigned COMPRESSED_MANIFEST_SIZE = 1,
  parameter int unsigned ESI_VERSION              = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  byte unsigned compressed_manifest [COMPRESSED_MANIFEST_SIZE],
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_addr,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [63:0]  rsp_data,
  output logic         rsp_error
);

  localparam int unsigned NW       = (COMPRESSED_MANIFEST_SIZE + 7) / 8;
  localparam int unsigned IW       = (COMPRESSED_MANIFEST_SIZE > 1) ? $clog2(COMPRESSED_MANIFEST_SIZE) : 1;
  localparam logic [32:0] DATA_END = 33'(16) + 33'(8 * NW);
  localparam logic [63:0] MAGIC    = 64'h207D98E5_E5100E51;
  localparam logic [63:0] HEADER   = {32'(ESI_VERSION), 32'(COMPRESSED_MANIFEST_SIZE)};

  typedef enum logic [1:0] {
    REGION_MAGIC,
    REGION_HEADER,
    REGION_DATA,
    REGION_ERROR
  } region_e;

  logic        stall;
  region_e     req_region;
  logic [31:0] req_index;
  logic [31:0] byte_idx;
  logic [63:0] data_word;

  logic        s1_valid_q,  s1_valid_d;
  region_e     s1_region_q, s1_region_d;
  logic [31:0] s1_index_q,  s1_index_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_data_q,  rsp_data_d;
  logic        rsp_error_q, rsp_error_d;

  assign stall     = rsp_valid_q & ~rsp_ready;
  assign req_ready = ~stall;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;

  // Range check is done in 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    req_region = REGION_ERROR;
    req_index  = '0;
    if (req_addr[2:0] != 3'b000) begin
      req_region = REGION_ERROR;
    end else if (req_addr == 32'h0) begin
      req_region = REGION_MAGIC;
    end else if (req_addr == 32'h8) begin
      req_region = REGION_HEADER;
    end else if ({1'b0, req_addr} < DATA_END) begin
      req_region = REGION_DATA;
      req_index  = {3'b000, req_addr[31:3]} - 32'd2;
    end
  end

  always_comb begin
    data_word = '0;
    byte_idx  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      byte_idx = (s1_index_q << 3) + i;
      if (byte_idx < COMPRESSED_MANIFEST_SIZE) begin
        data_word[8*i +: 8] = compressed_manifest[byte_idx[IW-1:0]];
      end
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_region_d = s1_region_q;
    s1_index_d  = s1_index_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    if (!stall) begin
      s1_valid_d  = req_valid;
      s1_region_d = req_region;
      s1_index_d  = req_index;
      rsp_valid_d = s1_valid_q;
      rsp_error_d = 1'b0;
      rsp_data_d  = '0;
      if (s1_valid_q) begin
        case (s1_region_q)
          REGION_MAGIC:  rsp_data_d  = MAGIC;
          REGION_HEADER: rsp_data_d  = HEADER;
          REGION_DATA:   rsp_data_d  = data_word;
          default:       rsp_error_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_region_q <= REGION_ERROR;
      s1_index_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_region_q <= s1_region_d;
      s1_index_q  <= s1_index_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

endmodule

// File: tb/tb_esi_manifest_mmio_reader.sv
// Scoreboard bench: two readers (11-byte and 8-byte manifests) share one request
// stream; expected responses come from an address-map model of the register window.
module tb_esi_manifest_mmio_reader;

  localparam int          SZ0   = 11;
  localparam int          SZ1   = 8;
  localparam logic [31:0] VER0  = 32'd1;
  localparam logic [31:0] VER1  = 32'h12345678;
  localparam logic [63:0] MAGIC = 64'h207D98E5_E5100E51;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        rsp_ready = 1'b0;
  logic [1:0]  req_ready_w;
  logic [1:0]  rsp_valid_w;
  logic [1:0]  rsp_error_w;
  logic [63:0] rsp_data_w [2];
  byte unsigned mem0 [SZ0];
  byte unsigned mem1 [SZ1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_total = 0;
  int last_stall [2] = '{-10, -10};
  logic        prev_stall [2] = '{1'b0, 1'b0};
  logic [64:0] prev_rsp [2];
  logic        prev_rst = 1'b0;
  logic        rand_done = 1'b0;

  typedef struct {
    logic        err;
    logic [63:0] data;
    int          acc;
    logic [31:0] addr;
  } exp_t;
  exp_t sbq [2][$];

  always #5 clk = ~clk;

  esi_manifest_mmio_reader #(.COMPRESSED_MANIFEST_SIZE(SZ0), .ESI_VERSION(VER0)) dut0 (
    .clk(clk), .rst(rst), .compressed_manifest(mem0),
    .req_valid(req_valid), .req_ready(req_ready_w[0]), .req_addr(req_addr),
    .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_w[0]), .rsp_error(rsp_error_w[0]));

  esi_manifest_mmio_reader #(.COMPRESSED_MANIFEST_SIZE(SZ1), .ESI_VERSION(VER1)) dut1 (
    .clk(clk), .rst(rst), .compressed_manifest(mem1),
    .req_valid(req_valid), .req_ready(req_ready_w[1]), .req_addr(req_addr),
    .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_w[1]), .rsp_error(rsp_error_w[1]));

  // Reference: {error, data} for a read of address a on reader d.
  function automatic logic [64:0] model(input int d, input logic [31:0] a);
    longint unsigned la   = 64'(a);
    longint unsigned size = (d == 0) ? 64'(SZ0) : 64'(SZ1);
    longint unsigned nw   = (size + 7) / 8;
    longint unsigned base;
    logic [63:0] data = '0;
    if (la % 8 != 0) return {1'b1, 64'h0};
    if (la == 0) return {1'b0, MAGIC};
    if (la == 8) return {1'b0, (d == 0) ? VER0 : VER1, size[31:0]};
    if (la >= 16 + 8 * nw) return {1'b1, 64'h0};
    base = la - 16;
    for (int i = 0; i < 8; i++) begin
      if (base + longint'(i) < size)
        data[8*i +: 8] = (d == 0) ? mem0[int'(base) + i] : mem1[int'(base) + i];
    end
    return {1'b0, data};
  endfunction

  task automatic check(input string name, input int d, input logic [65:0] act, input logic [65:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s dut%0d: actual %h required %h (t=%0t)", name, d, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Acceptance recorder: pushes the expected response of every accepted request.
  always @(negedge clk) begin
    if (rst) begin
      sbq[0].delete();
      sbq[1].delete();
    end else if (req_valid && req_ready_w[0]) begin
      acc_total++;
      for (int d = 0; d < 2; d++) begin
        logic [64:0] r;
        r = model(d, req_addr);
        sbq[d].push_back('{err: r[64], data: r[63:0], acc: cyc, addr: req_addr});
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        prev_stall[d] = 1'b0;
      end else begin
        if (prev_rst) begin
          check("post_reset_rsp_valid", d, 66'(rsp_valid_w[d]), 66'(0));
          check("post_reset_req_ready", d, 66'(req_ready_w[d]), 66'(1));
        end
        if (prev_stall[d])
          check("hold_stable", d, {rsp_valid_w[d], rsp_error_w[d], rsp_data_w[d]}, {1'b1, prev_rsp[d]});
        check("req_ready", d, 66'(req_ready_w[d]), 66'(!(rsp_valid_w[d] && !rsp_ready)));
        if (rsp_valid_w[d] && rsp_ready) begin
          if (sbq[d].size() == 0) begin
            check("unexpected_rsp", d, 66'(1), 66'(0));
          end else begin
            exp_t e;
            e = sbq[d].pop_front();
            check($sformatf("rsp@%h", e.addr), d, {1'b0, rsp_error_w[d], rsp_data_w[d]}, {1'b0, e.err, e.data});
            if (last_stall[d] < e.acc)
              check($sformatf("latency@%h", e.addr), d, 66'(cyc - e.acc), 66'(2));
          end
        end
        prev_stall[d] = rsp_valid_w[d] && !rsp_ready;
        if (prev_stall[d]) last_stall[d] = cyc;
        prev_rsp[d] = {rsp_error_w[d], rsp_data_w[d]};
      end
    end
    prev_rst = rst;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a);
    int w = 0;
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    while (!req_ready_w[0] && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!req_ready_w[0]) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: addr %h never accepted", a);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    case ($urandom_range(0, 7))
      0: r = 32'h0;
      1: r = 32'h8;
      2: r = 32'h10 + 32'(8 * $urandom_range(0, 3));
      3: begin r = $urandom; r[2:0] = 3'($urandom_range(1, 7)); end
      4: r = 32'hFFFF_FFF8;
      5: begin r = $urandom; r[2:0] = 3'b000; end
      6: r = 32'h10 | 32'($urandom_range(1, 7));
      default: r = 32'h18;
    endcase
    return r;
  endfunction

  initial begin
    int snap;
    int w;
    for (int i = 0; i < SZ0; i++) mem0[i] = 8'(i + 1);
    for (int i = 0; i < SZ1; i++) mem1[i] = 8'($urandom);
    idle(3);
    rst = 1'b0;
    rsp_ready = 1'b1;

    issue(32'h0);
    idle(3);
    issue(32'h08); issue(32'h10); issue(32'h18); issue(32'h20);
    idle(3);
    issue(32'h0C); issue(32'hFFFF_FFF8);
    idle(3);

    // Backpressure: only two requests fit before the stall reaches req_ready.
    rsp_ready = 1'b0;
    snap = acc_total;
    fork
      begin issue(32'h10); issue(32'h0); issue(32'h08); issue(32'h18); end
      begin
        repeat (5) @(negedge clk);
        check("stall_accepted", 0, 66'(acc_total - snap), 66'(2));
        check("stall_req_ready", 0, 66'(req_ready_w), 66'(0));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    idle(4);

    // Reset with two requests in flight.
    rsp_ready = 1'b0;
    issue(32'h10); issue(32'h18);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    idle(2);
    issue(32'h10);
    idle(3);

    fork
      begin
        repeat (300) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          else issue(rand_addr());
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        rsp_ready = 1'b1;
      end
    join

    w = 0;
    while ((sbq[0].size() != 0 || sbq[1].size() != 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    check("drain_q0", 0, 66'(sbq[0].size()), 66'(0));
    check("drain_q1", 1, 66'(sbq[1].size()), 66'(0));
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
